welcome_fade_renderer: RTL
==========================

Name: welcome_fade_renderer

Overview:
- Downstream consumer of the welcome-screen colour generator's 16-bit RGB565 colour word.
- Smoothly fades its displayed colour toward each new colour word, one LSB per channel per step.
- Renders the 96x64 OLED welcome frame: a border in the current faded colour, with the interior black.
- Drives oled_data for the OLED driver, indexed by the driver's pixel_index.

Parameters:
- STEP_DIV, 4096, clock cycles per fade step (>=1).
- BORDER, 3, border thickness in pixels (1..31).

Ports:
- clock  input  1  system clock; all state on posedge.
- resetn  input  1  asynchronous active-low reset.
- colour_in  input  16  RGB565 target colour: [15:11] R, [10:5] G, [4:0] B.
- pixel_index  input  13  current OLED pixel, 0..6143, row-major, x = idx mod 96, y = idx div 96.
- oled_data  output  16  RGB565 pixel to OLED driver.
- fade_busy  output  1  high while in FADE.
- fade_done  output  1  one-cycle pulse when a fade completes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- resetn low forces all registers to 0: colour_q, cur (R/G/B), tick counter, state=IDLE, oled_data, fade_busy, fade_done.
- colour_q registers colour_in every cycle, giving 1-cycle input latency. The target is always colour_q.
- FSM, IDLE:
  - tick counter held at 0.
  - If cur != colour_q, go to FADE next cycle and set fade_busy=1.
- FSM, FADE:
  - tick counter counts 0..STEP_DIV-1 and wraps to 0.
  - On the cycle where the counter equals STEP_DIV-1 (step event), each channel independently moves 1 toward its target: +1 if below, -1 if above, unchanged if equal.
  - R and B are 5-bit and G is 6-bit. There is no wrap or overflow, because a channel never steps past its target.
  - After a step, if all three channels equal colour_q: go to IDLE, clear fade_busy, and pulse fade_done for exactly 1 cycle, coincident with the first IDLE cycle.
- Fade length: max(|dR|, |dG|, |dB|) steps × STEP_DIV cycles.
- Retarget mid-fade (colour_q changes during FADE):
  - stay in FADE.
  - keep cur and the tick counter; do not restart the counter.
  - subsequent steps move toward the new target.
  - If colour_q changes back to equal cur exactly on a step event, the step makes no change and the fade completes on that step.
- colour_q equal to cur in IDLE: no state change and no fade_done.
- Rendering, oled_data is registered with 1-cycle latency from pixel_index:
  - pixel_index >= 6144: output 0x0000.
  - border pixel (x < BORDER, or x >= 96-BORDER, or y < BORDER, or y >= 64-BORDER): output {curR, curG, curB}, using cur as it is in the cycle pixel_index is sampled.
  - any other pixel: output 0x0000.
- x/y derivation may be combinational (divide/modulo by the constant 96). It must meet timing at the system clock with no extra pipeline stage.
- Reset asserted mid-fade: state is cleared immediately. After release, the block starts a new fade from 0 if colour_q != 0.

Optional Feature:
- Macro: DIM_INTERIOR_EN.
- Defined: interior (non-border, in-range) pixels output the current colour at half intensity, {curR>>1, curG>>1, curB>>1}, packed as RGB565. Latency is unchanged.
- Undefined: interior pixels output 0x0000 as above. No extra logic is synthesised.

Test Plan:
- Reset:
  - Stimulus: hold resetn=0 with colour_in=0xFFFF and pixel_index=0, then release.
  - Required: oled_data=0, fade_busy=0 while in reset; fade_busy rises 2 cycles after release.
- Basic fade (STEP_DIV=4):
  - Stimulus: colour 0x0000 -> 0x001F.
  - Required: curB increments every 4 cycles; oled_data at index 0 reaches 0x001F after 31×4 cycles; fade_done pulses once; fade_busy falls the same cycle.
- Green width (STEP_DIV=1):
  - Stimulus: colour 0x0000 -> 0x07E0.
  - Required: 63 steps; final border pixel 0x07E0; R and B stay 0 throughout.
- Retarget (STEP_DIV=2):
  - Stimulus: fade toward 0xF800; once curR=10, change colour_in to 0x0000.
  - Required: R counts back 10 -> 0; no fade_done until R=0; fade_busy stays high continuously.
- Geometry (BORDER=3, cur=0xFFFF):
  - Stimulus and required outputs, each 1 cycle later:
    - index 0 -> 0xFFFF.
    - index 2 -> 0xFFFF.
    - index 3×96+3=291 -> 0x0000.
    - index 95 -> 0xFFFF.
    - index 63×96=6048 -> 0xFFFF.
    - index 6144 -> 0x0000.
  - With DIM_INTERIOR_EN defined, index 291 -> 0x7BEF.
- Reset mid-fade:
  - Stimulus: assert resetn=0 asynchronously while fading toward 0xFFFF.
  - Required: oled_data and fade_busy drop to 0 without waiting for a clock edge; after release, the fade restarts from 0x0000.

Source files
------------

// File: rtl/welcome_fade_renderer.sv
// welcome_fade_renderer: fades the welcome-frame border colour toward colour_in
// one LSB per channel per STEP_DIV cycles and renders the 96x64 OLED frame.
// Ports: clock, resetn (async, active-low), colour_in[15:0] RGB565 target,
//   pixel_index[12:0] OLED pixel, oled_data[15:0] registered pixel colour,
//   fade_busy (high in FADE), fade_done (1-cycle pulse on fade completion).
// Build option: define DIM_INTERIOR_EN to paint the interior at half intensity.
module welcome_fade_renderer #(
    parameter int STEP_DIV = 4096,
    parameter int BORDER   = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] colour_in,
    input  logic [12:0] pixel_index,
    output logic [15:0] oled_data,
    output logic        fade_busy,
    output logic        fade_done
);

    // A 1-bit counter still works for STEP_DIV=1: it sits at 0 = last.
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    localparam logic [12:0] B_LO  = 13'(BORDER);
    localparam logic [12:0] X_HI  = 13'(96 - BORDER);
    localparam logic [12:0] Y_HI  = 13'(64 - BORDER);
    localparam logic [12:0] NPIX  = 13'd6144;

    typedef enum logic {
        IDLE,
        FADE
    } state_t;

    state_t        state, state_n;
    logic [15:0]   colour_q;
    logic [4:0]    cur_r, cur_b, cur_r_n, cur_b_n;
    logic [5:0]    cur_g, cur_g_n;
    logic [CW-1:0] tick, tick_n;
    logic          done_n;

    logic [4:0]    tgt_r, tgt_b, step_r, step_b;
    logic [5:0]    tgt_g, step_g;
    logic          step;

    assign tgt_r = colour_q[15:11];
    assign tgt_g = colour_q[10:5];
    assign tgt_b = colour_q[4:0];
    assign step  = (tick == LAST);

    // One LSB toward target; equal channels hold, so no channel overshoots.
    always_comb begin
        step_r = cur_r;
        step_g = cur_g;
        step_b = cur_b;
        if (cur_r < tgt_r) step_r = cur_r + 5'd1;
        if (cur_r > tgt_r) step_r = cur_r - 5'd1;
        if (cur_g < tgt_g) step_g = cur_g + 6'd1;
        if (cur_g > tgt_g) step_g = cur_g - 6'd1;
        if (cur_b < tgt_b) step_b = cur_b + 5'd1;
        if (cur_b > tgt_b) step_b = cur_b - 5'd1;
    end

    always_comb begin
        state_n = state;
        tick_n  = '0;
        cur_r_n = cur_r;
        cur_g_n = cur_g;
        cur_b_n = cur_b;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if ({cur_r, cur_g, cur_b} != colour_q)
                    state_n = FADE;
            end
            FADE: begin
                if (step) begin
                    cur_r_n = step_r;
                    cur_g_n = step_g;
                    cur_b_n = step_b;
                    if ({step_r, step_g, step_b} == colour_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    tick_n = tick + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [12:0] px_x, px_y;
    logic        in_range, on_border, border_hit;
    logic [15:0] pix_n;

    assign px_x       = pixel_index % 13'd96;
    assign px_y       = pixel_index / 13'd96;
    assign in_range   = (pixel_index < NPIX);
    assign on_border  = (px_x < B_LO) || (px_x >= X_HI) ||
                        (px_y < B_LO) || (px_y >= Y_HI);
    assign border_hit = in_range && on_border;

`ifdef DIM_INTERIOR_EN
    logic interior;
    assign interior = in_range && !on_border;

    always_comb begin
        pix_n = 16'h0000;
        unique case (1'b1)
            border_hit: pix_n = {cur_r, cur_g, cur_b};
            interior:   pix_n = {1'b0, cur_r[4:1],
                                 1'b0, cur_g[5:1],
                                 1'b0, cur_b[4:1]};
            default:    pix_n = 16'h0000;
        endcase
    end
`else
    always_comb begin
        pix_n = 16'h0000;
        if (border_hit)
            pix_n = {cur_r, cur_g, cur_b};
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            colour_q  <= '0;
            state     <= IDLE;
            tick      <= '0;
            cur_r     <= '0;
            cur_g     <= '0;
            cur_b     <= '0;
            oled_data <= '0;
            fade_busy <= 1'b0;
            fade_done <= 1'b0;
        end else begin
            colour_q  <= colour_in;
            state     <= state_n;
            tick      <= tick_n;
            cur_r     <= cur_r_n;
            cur_g     <= cur_g_n;
            cur_b     <= cur_b_n;
            oled_data <= pix_n;
            fade_busy <= (state_n == FADE);
            fade_done <= done_n;
        end
    end

endmodule
